// File: rtl/riscv_keypad_scanner.sv
// 4x4 matrix keypad scanner: drives rows in turn, debounces whole-frame results, presents {valid, code}.
// Build option RISCV_KEYPAD_LATCH_EN: a debounced key stays on keyboard until kb_ack clears it.
module riscv_keypad_scanner #(
    parameter int SCAN_DIV        = 1000,
    parameter int DEBOUNCE_FRAMES = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] col_in,
    input  logic       kb_ack,
    output logic [3:0] row_out,
    output logic [4:0] keyboard
);
    localparam int DIV_W = $clog2(SCAN_DIV);
    localparam int CNT_W = $clog2(DEBOUNCE_FRAMES + 1);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(DEBOUNCE_FRAMES);
    localparam logic [4:0]       NO_KEY   = 5'b0_0000;

    logic [3:0]       col_meta;
    logic [3:0]       col_s;
    logic [DIV_W-1:0] div;
    logic [1:0]       row_idx;
    logic             hit_found;
    logic [3:0]       hit_code;
    logic [4:0]       cand;
    logic [4:0]       stable;
    logic [CNT_W-1:0] deb_cnt;

    logic             sample;
    logic             frame_end;
    logic             row_hit;
    logic [1:0]       row_col;
    logic [4:0]       frame_res;
    logic [CNT_W-1:0] cnt_next;
    logic             stable_load;

    assign row_out = ~(4'b0001 << row_idx);

    // Lowest pressed column wins inside a row; an earlier row's hit wins over this one.
    always_comb begin
        sample      = (div == DIV_LAST);
        frame_end   = sample && (row_idx == 2'd3);
        row_hit     = 1'b0;
        row_col     = 2'd0;
        for (int c = 3; c >= 0; c--) begin
            if (!col_s[c]) begin
                row_hit = 1'b1;
                row_col = 2'(c);
            end
        end
        if (hit_found) begin
            frame_res = {1'b1, hit_code};
        end else if (row_hit) begin
            frame_res = {1'b1, row_idx, row_col};
        end else begin
            frame_res = NO_KEY;
        end
        if (frame_res != cand) begin
            cnt_next = CNT_W'(1);
        end else if (deb_cnt == CNT_MAX) begin
            cnt_next = deb_cnt;
        end else begin
            cnt_next = deb_cnt + CNT_W'(1);
        end
        stable_load = frame_end && (cnt_next == CNT_MAX) && (frame_res != stable);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            col_meta <= 4'b1111;
            col_s    <= 4'b1111;
        end else begin
            col_meta <= col_in;
            col_s    <= col_meta;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div     <= '0;
            row_idx <= 2'd0;
        end else if (sample) begin
            div     <= '0;
            row_idx <= row_idx + 2'd1;
        end else begin
            div     <= div + DIV_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hit_found <= 1'b0;
            hit_code  <= 4'd0;
        end else if (frame_end) begin
            hit_found <= 1'b0;
        end else if (sample && row_hit && !hit_found) begin
            hit_found <= 1'b1;
            hit_code  <= {row_idx, row_col};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cand    <= NO_KEY;
            stable  <= NO_KEY;
            deb_cnt <= '0;
        end else if (frame_end) begin
            cand    <= frame_res;
            deb_cnt <= cnt_next;
            if (stable_load) begin
                stable <= frame_res;
            end
        end
    end

`ifdef RISCV_KEYPAD_LATCH_EN
    logic stable_new;

    // A fresh debounced key beats a simultaneous acknowledge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stable_new <= 1'b0;
            keyboard   <= NO_KEY;
        end else begin
            stable_new <= stable_load && frame_res[4];
            if (stable_new) begin
                keyboard <= stable;
            end else if (kb_ack) begin
                keyboard <= NO_KEY;
            end
        end
    end
`else
    logic unused_kb_ack;
    assign unused_kb_ack = kb_ack;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            keyboard <= NO_KEY;
        end else begin
            keyboard <= stable;
        end
    end
`endif

endmodule

// File: tb/tb_riscv_keypad_scanner.sv
// Self-checking bench for riscv_keypad_scanner with a frame-level reference model and a physical keypad model.
// Honours RISCV_KEYPAD_LATCH_EN when the design is built with it.
module tb_riscv_keypad_scanner;
    localparam int SD = 4;
    localparam int DF = 3;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  col_in;
    logic        kb_ack = 1'b0;
    logic [3:0]  row_out;
    logic [4:0]  keyboard;
    logic [15:0] keys = 16'h0000;

    int checks = 0;
    int errors = 0;

    int          m_c;
    logic [3:0]  m_cv1;
    logic [3:0]  m_cv2;
    logic [15:0] m_samples;
    logic [4:0]  m_frames[$];
    logic [4:0]  m_stable;
    logic [4:0]  m_kb;
    logic        m_new;

    always #5 clk = ~clk;

    riscv_keypad_scanner #(.SCAN_DIV(SD), .DEBOUNCE_FRAMES(DF)) dut (
        .clk(clk),
        .rst(rst),
        .col_in(col_in),
        .kb_ack(kb_ack),
        .row_out(row_out),
        .keyboard(keyboard)
    );

    // Physical keypad: a pressed key shorts its column to its row while that row is driven low.
    always_comb begin
        col_in = 4'hF;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (keys[r*4+c] && !row_out[r]) col_in[c] = 1'b0;
    end

    task automatic checkOutput(input string name, input logic [7:0] actual, input logic [7:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Scan order is row-major, so bit index r*4+c of the frame samples is also the key code.
    function automatic logic [4:0] frameResult(input logic [15:0] s);
        for (int i = 0; i < 16; i++)
            if (!s[i]) return {1'b1, 4'(i)};
        return 5'd0;
    endfunction

    always @(negedge clk) begin
        if (rst) begin
            checkOutput("reset_row", {4'd0, row_out}, 8'h0E);
            checkOutput("reset_kb", {3'd0, keyboard}, 8'h00);
            m_c = 0;
            m_cv1 = 4'hF;
            m_cv2 = 4'hF;
            m_samples = 16'hFFFF;
            m_frames.delete();
            m_stable = 5'd0;
            m_kb = 5'd0;
            m_new = 1'b0;
        end else begin
            int row;
            logic [3:0] exp_row;
            logic [3:0] col_now;
            logic [4:0] res;
            logic same;
            row = (m_c / SD) % 4;
            exp_row = 4'hF;
            exp_row[row] = 1'b0;
            checkOutput("model_row", {4'd0, row_out}, {4'd0, exp_row});
            checkOutput("model_kb", {3'd0, keyboard}, {3'd0, m_kb});
`ifdef RISCV_KEYPAD_LATCH_EN
            if (m_new) m_kb = m_stable;
            else if (kb_ack) m_kb = 5'd0;
`else
            m_kb = m_stable;
`endif
            m_new = 1'b0;
            col_now = 4'hF;
            for (int c = 0; c < 4; c++)
                if (keys[row*4+c]) col_now[c] = 1'b0;
            if (m_c % SD == SD - 1) begin
                m_samples[row*4 +: 4] = m_cv2;
                if (row == 3) begin
                    res = frameResult(m_samples);
                    m_samples = 16'hFFFF;
                    m_frames.push_back(res);
                    if (m_frames.size() > DF) void'(m_frames.pop_front());
                    same = (m_frames.size() == DF);
                    foreach (m_frames[j])
                        if (m_frames[j] != res) same = 1'b0;
                    if (same && res != m_stable) begin
                        m_stable = res;
                        m_new = res[4];
                    end
                end
            end
            m_cv2 = m_cv1;
            m_cv1 = col_now;
            m_c++;
        end
    end

    task automatic applyStimulus(input logic [15:0] k, input logic ack);
        @(posedge clk);
        #2;
        keys = k;
        kb_ack = ack;
    endtask

    task automatic waitKb(input string name, input logic [4:0] target, input int limit);
        for (int i = 0; i < limit; i++) begin
            if (keyboard == target) break;
            applyStimulus(keys, 1'b0);
        end
        checkOutput(name, {3'd0, keyboard}, {3'd0, target});
    endtask

    task automatic releaseKeys(input string name, input logic [4:0] held);
        checkOutput({name, "_pre"}, {3'd0, keyboard}, {3'd0, held});
        applyStimulus(16'h0000, 1'b0);
`ifdef RISCV_KEYPAD_LATCH_EN
        repeat (66) applyStimulus(16'h0000, 1'b0);
        checkOutput({name, "_held"}, {3'd0, keyboard}, {3'd0, held});
        applyStimulus(16'h0000, 1'b1);
        applyStimulus(16'h0000, 1'b0);
        checkOutput({name, "_ack"}, {3'd0, keyboard}, 8'h00);
`else
        waitKb({name, "_rel"}, 5'd0, 66);
`endif
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: got timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [3:0]  row_exp [4];
        logic [4:0]  seen;
        logic [15:0] next_k;
        int          hold;
        int          rst_at;
        row_exp[0] = 4'b1110;
        row_exp[1] = 4'b1101;
        row_exp[2] = 4'b1011;
        row_exp[3] = 4'b0111;

        $display("[TB] start");
        repeat (3) @(posedge clk);
        #2;
        checkOutput("rst_kb_lit", {3'd0, keyboard}, 8'h00);
        checkOutput("rst_row_lit", {4'd0, row_out}, 8'h0E);
        rst = 1'b0;

        checkOutput("row_seq0", {4'd0, row_out}, {4'd0, row_exp[0]});
        for (int i = 1; i < 8; i++) begin
            repeat (SD) applyStimulus(16'h0000, 1'b0);
            checkOutput("row_seq", {4'd0, row_out}, {4'd0, row_exp[i % 4]});
        end
        seen = 5'd0;
        repeat (40) begin
            applyStimulus(16'h0000, 1'b0);
            seen |= keyboard;
        end
        checkOutput("idle_kb", {3'd0, seen}, 8'h00);

        applyStimulus(16'h1 << 9, 1'b0);
        waitKb("press_21", 5'h19, 66);
        repeat (20) applyStimulus(16'h1 << 9, 1'b0);
        checkOutput("hold_21", {3'd0, keyboard}, 8'h19);
        releaseKeys("key_21", 5'h19);

        repeat (48) applyStimulus(16'h0000, 1'b0);
        for (int i = 0; i < 4; i++)
            if ((m_c + 1) % 4 != 2) applyStimulus(16'h0000, 1'b0);
        seen = 5'd0;
        for (int i = 0; i < 200; i++) begin
            applyStimulus(((i / 10) % 2 == 0) ? (16'h1 << 9) : 16'h0000, 1'b0);
            seen |= keyboard;
        end
        repeat (64) begin
            applyStimulus(16'h0000, 1'b0);
            seen |= keyboard;
        end
        checkOutput("bounce_quiet", {3'd0, seen}, 8'h00);

        applyStimulus((16'h1 << 7) | (16'h1 << 8), 1'b0);
        waitKb("two_keys", 5'h17, 66);
        releaseKeys("two_keys", 5'h17);

        applyStimulus(16'h1 << 2, 1'b0);
        repeat (40) applyStimulus(16'h1 << 2, 1'b0);
        checkOutput("pre_rst_02", {3'd0, keyboard}, 8'h00);
        applyStimulus(16'h1 << 2, 1'b0);
        rst = 1'b1;
        repeat (3) applyStimulus(16'h1 << 2, 1'b0);
        checkOutput("mid_rst_kb", {3'd0, keyboard}, 8'h00);
        checkOutput("mid_rst_row", {4'd0, row_out}, 8'h0E);
        rst = 1'b0;
        repeat (48) applyStimulus(16'h1 << 2, 1'b0);
        checkOutput("rst_3frames_before", {3'd0, keyboard}, 8'h00);
        applyStimulus(16'h1 << 2, 1'b0);
        checkOutput("rst_3frames_after", {3'd0, keyboard}, 8'h12);
        releaseKeys("key_02", 5'h12);

`ifdef RISCV_KEYPAD_LATCH_EN
        applyStimulus(16'h1 << 15, 1'b0);
        waitKb("press_33", 5'h1F, 66);
        releaseKeys("latch_33", 5'h1F);
`endif

        hold = 0;
        next_k = 16'h0000;
        rst_at = int'($urandom_range(200, 800));
        for (int i = 0; i < 1000; i++) begin
            if (hold == 0) begin
                case ($urandom_range(0, 3))
                    0: next_k = 16'h0000;
                    1, 2: next_k = 16'h1 << $urandom_range(0, 15);
                    default: next_k = (16'h1 << $urandom_range(0, 15)) | (16'h1 << $urandom_range(0, 15));
                endcase
                hold = int'($urandom_range(4, 140));
            end else begin
                hold--;
            end
            applyStimulus(next_k, $urandom_range(0, 15) == 0);
            if (i == rst_at) rst = 1'b1;
            else if (i == rst_at + 3) rst = 1'b0;
        end
        applyStimulus(16'h0000, 1'b0);
        repeat (4) applyStimulus(16'h0000, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/riscv_keypad_scanner.md
Name: riscv_keypad_scanner

Overview:
- Device-side producer of the 5-bit `keyboard` word that the CPU reads through the memory-mapped IO window at 0xfffffc08.
- Drives a 4x4 matrix keypad row by row and synchronises the column returns.
- Debounces the scan result across whole scan frames.
- Presents {valid, code[3:0]} to the IO bridge.

Parameters:
- SCAN_DIV, 1000: clk cycles each row is driven; columns are sampled on the last cycle of the row period; legal range >= 4.
- DEBOUNCE_FRAMES, 8: consecutive identical frame results required before the stable output changes; legal range >= 1.

Ports:
- clk  input  1  system clock
- rst  input  1  asynchronous, active-high reset
- col_in  input  4  keypad columns, active-low, externally pulled up, asynchronous to clk
- kb_ack  input  1  one-cycle pulse from the bridge; used only with the optional feature
- row_out  output  4  row drive, active-low, one-hot-zero
- keyboard  output  5  bit4 = key valid, bits3:0 = key code; connects to the bridge keyboard input

Behaviour:
- Reset is asynchronous, active-high.
- Reset values:
  - row_out = 4'b1110
  - keyboard = 5'b0_0000
  - row index = 0, divider = 0, debounce count = 0
  - candidate and stable = "no key"
  - synchroniser flops = 4'b1111
- Synchroniser: col_in passes through a 2-flop synchroniser before any use (col_s).
- Row sequencing:
  - Row index r counts 0..3 and wraps; row_out = ~(4'b0001 << r).
  - Divider counts 0..SCAN_DIV-1. At SCAN_DIV-1 the block samples col_s for row r, then advances r.
  - row_out changes on the cycle after the sample.
- Frame scan:
  - Per-frame "first hit" is in scan order: row 0 col 0 first, row 3 col 3 last.
  - The first low col_s bit found in the frame is recorded as hit = {r[1:0], c[1:0]}. Later hits in the same frame are ignored.
  - No low bit anywhere in the frame gives the result "no key".
- Frame end (sample of row 3):
  - frame_res = hit, or "no key".
  - If frame_res equals the previous frame_res, increment the debounce count, saturating at DEBOUNCE_FRAMES. Otherwise load the count with 1.
  - When the count reaches DEBOUNCE_FRAMES and frame_res differs from stable: stable <= frame_res, and keyboard updates on the next clk edge.
  - keyboard = {1'b1, code} for a key; 5'b0_0000 for "no key".
- Latency:
  - A key held steadily from before a frame start appears DEBOUNCE_FRAMES frames plus up to 2 cycles (synchroniser) later.
  - One frame = 4*SCAN_DIV cycles; worst case adds one partial frame.
- Boundary conditions:
  - A bounce anywhere inside a frame changes frame_res and resets the debounce count to 1. Stable is held.
  - Key held across a row wrap: no glitch on keyboard; keyboard changes only at frame end.
  - Reset mid-frame or mid-debounce: everything returns to reset values immediately; the first frame restarts from row 0.
  - Counter widths are $clog2(SCAN_DIV) for the divider and $clog2(DEBOUNCE_FRAMES+1) for the debounce count; neither overflows.

Optional Feature:
- Macro: RISCV_KEYPAD_LATCH_EN.
- Defined:
  - A stable transition to a key sets keyboard = {1, code}, and keyboard holds after release until a kb_ack pulse clears it to 0.
  - A new, different debounced key overwrites the latched code.
  - If kb_ack arrives in the same cycle as a new key update, the new key wins.
- Not defined: kb_ack is ignored; keyboard tracks the stable state directly.

Test Plan (SCAN_DIV=4, DEBOUNCE_FRAMES=3, frame = 16 cycles; bench keypad model pulls col c low while row r is low and key (r,c) is pressed):
- Reset release, no keys -> row_out cycles 1110, 1101, 1011, 0111 every 4 cycles; keyboard stays 5'h00.
- Press (2,1) steady -> keyboard = 5'b1_1001 within 4 frames + 2 cycles (<= 66 cycles); release -> 5'h00 within the same bound.
- Press (2,1) toggling every 10 cycles for 200 cycles, then release -> keyboard never leaves 5'h00.
- Press (1,3) and (2,0) together -> keyboard = 5'b1_0111.
- Assert rst after 2 matching frames of key (0,2), release rst -> keyboard 5'h00, row_out 1110; 5'b1_0010 appears only after 3 further full frames.
- RISCV_KEYPAD_LATCH_EN defined: press/debounce/release key (3,3) -> keyboard holds 5'b1_1111; kb_ack pulse -> 5'h00 next cycle.
